// File: rtl/hdmi_pkg.sv
// Shared types and helpers for the HDMI pixel fetch path.
// Holds the fetch FSM states, pixel-format codes and the line-length helper.
package hdmi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitAck,
        StData,
        StHold,
        StDrain
    } fetch_state_e;

    localparam logic BPP_RGB888 = 1'b1;
    localparam logic BPP_RGB565 = 1'b0;

    // RGB565 packs two pixels per word, so an odd pixel count rounds up.
    function automatic logic [11:0] words_per_line(input logic [10:0] hres, input logic bpp);
        logic [11:0] h;
        h = {1'b0, hres};
        return (bpp == BPP_RGB565) ? ((h + 12'd1) >> 1) : h;
    endfunction

endpackage

// File: rtl/hdmi_fwft_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on rdata_o without a read cycle.
// Pushes into a full FIFO and pops from an empty one are ignored.
module hdmi_fwft_fifo #(
    parameter int unsigned Depth = 128,
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_pixel_fetch.sv
// Prefetches framebuffer lines in memory bursts into a FWFT FIFO for the HDMI output core.
// Line and frame sequencing follow the core's read_go / read_next_line / read_done pulses.
module hdmi_pixel_fetch
    import hdmi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 128,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [10:0]       hres,
    input  logic              num_bytes_per_pixel,
    input  logic              read_go,
    input  logic              read_next_line,
    input  logic              read_done,
    input  logic              read_fifo,
    output logic [31:0]       color,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_len,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              underflow,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d, cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] base_q, base_d, mem_addr_q, mem_addr_d, start_base;
    logic [11:0]       remaining_q, remaining_d, wpl, burst_w;
    logic [7:0]        beats_q, beats_d, mem_len_q, mem_len_d;
    logic              mem_req_q, mem_req_d, underflow_q, underflow_d;
    logic              restart_q, restart_d, done_q, done_d, nl_pend_q, nl_pend_d;
    logic              start, fifo_flush, fifo_push, fifo_full, fifo_empty, fits;
    logic [31:0]       fifo_rdata, need;
    logic [CntW-1:0]   fifo_count;
    logic [ADDR_W-1:0] line_bytes;

    assign wpl        = words_per_line(hres, num_bytes_per_pixel);
    assign line_bytes = ADDR_W'({wpl, 2'b00});
    assign burst_w    = (remaining_q > 12'(BURST_LEN)) ? 12'(BURST_LEN) : remaining_q;
    assign need       = 32'(fifo_count) + 32'(beats_q) + 32'(burst_w);
    assign fits       = (need <= FIFO_DEPTH);
    assign fifo_push  = (state_q == StData) && mem_rvalid;

    hdmi_fwft_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (32)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (mem_rdata),
        .pop_i   (read_fifo),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        cur_addr_d  = cur_addr_q;
        base_d      = base_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_len_d   = mem_len_q;
        restart_d   = restart_q;
        done_d      = done_q;
        nl_pend_d   = nl_pend_q;
        underflow_d = underflow_q | (read_fifo & fifo_empty);
        start       = 1'b0;
        start_base  = fb_base;
        fifo_flush  = 1'b0;

        if (read_next_line && state_q != StHold && state_q != StIdle) nl_pend_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (read_go) start = 1'b1;
            end
            StReq: begin
                if (read_go) begin
                    start = 1'b1;
                end else if (read_done) begin
                    state_d = StIdle;
                end else if (remaining_q == '0) begin
                    state_d = StHold;
                end else if (fits) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = cur_addr_q;
                    mem_len_d  = burst_w[7:0];
                    state_d    = StWaitAck;
                end
            end
            StWaitAck: begin
                if (read_go) begin
                    restart_d = 1'b1;
                    base_d    = fb_base;
                end
                if (read_go || read_done) done_d = 1'b1;
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    cur_addr_d  = cur_addr_q + ADDR_W'({mem_len_q, 2'b00});
                    remaining_d = remaining_q - 12'(mem_len_q);
                    beats_d     = mem_len_q;
                    state_d     = done_d ? StDrain : StData;
                    done_d      = 1'b0;
                end
            end
            StData: begin
                if (mem_rvalid) beats_d = beats_q - 8'd1;
                if (read_go) begin
                    restart_d = 1'b1;
                    base_d    = fb_base;
                    state_d   = StDrain;
                end else if (read_done) begin
                    state_d = StDrain;
                end else if (mem_rvalid && beats_q == 8'd1) begin
                    state_d = StReq;
                end
            end
            StHold: begin
                if (read_go) begin
                    start = 1'b1;
                end else if (read_done) begin
                    state_d = StIdle;
                end else if (read_next_line || nl_pend_q) begin
                    line_addr_d = line_addr_q + line_bytes;
                    cur_addr_d  = line_addr_q + line_bytes;
                    remaining_d = wpl;
                    nl_pend_d   = 1'b0;
                    state_d     = StReq;
                end
            end
            StDrain: begin
                if (read_go) begin
                    restart_d = 1'b1;
                    base_d    = fb_base;
                end
                if (mem_rvalid && beats_q != '0) beats_d = beats_q - 8'd1;
                if (beats_d == '0) begin
                    fifo_flush = 1'b1;
                    if (restart_d) begin
                        start      = 1'b1;
                        start_base = base_d;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            fifo_flush  = 1'b1;
            line_addr_d = start_base;
            cur_addr_d  = start_base;
            remaining_d = wpl;
            underflow_d = 1'b0;
            restart_d   = 1'b0;
            done_d      = 1'b0;
            nl_pend_d   = 1'b0;
            state_d     = StReq;
        end
        if (state_d == StIdle) nl_pend_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            line_addr_q <= '0;
            cur_addr_q  <= '0;
            base_q      <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_len_q   <= '0;
            underflow_q <= 1'b0;
            restart_q   <= 1'b0;
            done_q      <= 1'b0;
            nl_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            cur_addr_q  <= cur_addr_d;
            base_q      <= base_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_len_q   <= mem_len_d;
            underflow_q <= underflow_d;
            restart_q   <= restart_d;
            done_q      <= done_d;
            nl_pend_q   <= nl_pend_d;
        end
    end

    assign color     = fifo_empty ? 32'd0 : fifo_rdata;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_len   = mem_len_q;
    assign underflow = underflow_q;
    assign busy      = (state_q != StIdle);

    a_nl_double: assert property (@(posedge clock) disable iff (!reset_n)
        !(read_next_line && nl_pend_q && state_q != StHold));
    a_beat_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(fifo_push && fifo_full));

endmodule

// File: tb/tb_hdmi_pixel_fetch.sv
// Directed bench for hdmi_pixel_fetch with a simple burst memory responder.
// Read data is the word index relative to tb_base, so FIFO contents are predictable.
module tb_hdmi_pixel_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] fb_base = 32'h0;
    logic [10:0] hres = 11'd800;
    logic        num_bytes_per_pixel = 1'b1;
    logic        read_go = 1'b0, read_next_line = 1'b0, read_done = 1'b0, read_fifo = 1'b0;
    logic [31:0] color;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_len;
    logic        mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        underflow, busy;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    hdmi_pixel_fetch dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .fb_base             (fb_base),
        .hres                (hres),
        .num_bytes_per_pixel (num_bytes_per_pixel),
        .read_go             (read_go),
        .read_next_line      (read_next_line),
        .read_done           (read_done),
        .read_fifo           (read_fifo),
        .color               (color),
        .mem_req             (mem_req),
        .mem_addr            (mem_addr),
        .mem_len             (mem_len),
        .mem_ack             (mem_ack),
        .mem_rvalid          (mem_rvalid),
        .mem_rdata           (mem_rdata),
        .underflow           (underflow),
        .busy                (busy)
    );

    // Memory responder: acks one burst at a time, then streams its beats back to back.
    int          nbursts, m_beats, m_left;
    int          m_limit = 1000;
    int          m_stop = 1000000;
    logic [31:0] tb_base = 32'h0;
    logic [31:0] m_addr;
    bit          m_busy;
    logic [31:0] b_addr [64];
    logic [7:0]  b_len  [64];

    always @(posedge clock) begin
        #1;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        if (!reset_n) begin
            m_busy  = 1'b0;
            nbursts = 0;
            m_beats = 0;
        end else if (m_busy) begin
            if (m_beats < m_stop) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (m_addr - tb_base) >> 2;
                m_addr     = m_addr + 32'd4;
                m_beats++;
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end
        end else if (mem_req && nbursts < m_limit) begin
            mem_ack = 1'b1;
            if (nbursts < 64) begin
                b_addr[nbursts] = mem_addr;
                b_len[nbursts]  = mem_len;
            end
            nbursts++;
            m_busy = 1'b1;
            m_left = int'(mem_len);
            m_addr = mem_addr;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        read_fifo = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic go(input logic [31:0] base);
        @(negedge clock);
        fb_base = base;
        tb_base = base;
        read_go = 1'b1;
        @(negedge clock);
        read_go = 1'b0;
    endtask

    task automatic wait_bursts(input int n, input int budget);
        int k = 0;
        while (nbursts < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check($sformatf("wait_bursts_%0d", n), nbursts, n);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (m_beats < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check($sformatf("wait_beats_%0d", n), m_beats, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_len", mem_len, 0);
        check("rst_underflow", underflow, 0);
        check("rst_busy", busy, 0);
        check("rst_color", color, 0);

        // Pop timing: one burst of words 0..63, popped back to back.
        m_limit = 1;
        go(32'h1000);
        wait_beats(64, 500);
        repeat (2) @(negedge clock);
        check("first_addr", b_addr[0], 32'h1000);
        check("first_len", b_len[0], 64);
        read_fifo = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("pop_seq_%0d", i), color, i);
            @(negedge clock);
        end
        read_fifo = 1'b0;
        check("pop_empty_color", color, 0);
        check("pop_no_underflow", underflow, 0);
        read_fifo = 1'b1;
        @(negedge clock);
        read_fifo = 1'b0;
        check("underflow_set", underflow, 1);
        check("underflow_color", color, 0);

        // Single-cycle reset while a request is pending.
        check("req_before_rst", mem_req, 1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("rst1_mem_req", mem_req, 0);
        check("rst1_color", color, 0);
        check("rst1_busy", busy, 0);
        check("rst1_underflow", underflow, 0);
        m_limit = 1000;

        // Backpressure, then a full RGB888 line of 800 words and the next-line stride.
        go(32'h1000);
        repeat (400) @(negedge clock);
        check("bp_bursts", nbursts, 2);
        check("bp_addr1", b_addr[1], 32'h1100);
        check("bp_len1", b_len[1], 64);
        check("bp_req_low", mem_req, 0);
        check("bp_busy", busy, 1);
        read_fifo = 1'b1;
        repeat (63) @(negedge clock);
        read_fifo = 1'b0;
        check("bp_head", color, 63);
        repeat (20) @(negedge clock);
        check("bp_still2", nbursts, 2);
        read_fifo = 1'b1;
        @(negedge clock);
        read_fifo = 1'b0;
        wait_bursts(3, 100);
        check("bp_addr2", b_addr[2], 32'h1200);
        read_fifo = 1'b1;
        wait_bursts(13, 3000);
        check("line_last_addr", b_addr[12], 32'h1C00);
        check("line_last_len", b_len[12], 32);
        repeat (200) @(negedge clock);
        check("hold_no_req", nbursts, 13);
        read_next_line = 1'b1;
        @(negedge clock);
        read_next_line = 1'b0;
        wait_bursts(14, 200);
        check("line2_addr", b_addr[13], 32'h1C80);
        check("line2_len", b_len[13], 64);
        read_fifo = 1'b0;

        // read_done with 20 beats of the first burst still outstanding.
        do_reset();
        m_stop = 44;
        go(32'h2000);
        wait_beats(44, 500);
        repeat (3) @(negedge clock);
        check("done_busy_before", busy, 1);
        read_done = 1'b1;
        @(negedge clock);
        read_done = 1'b0;
        m_stop = 1000000;
        repeat (40) @(negedge clock);
        check("done_beats", m_beats, 64);
        check("done_busy", busy, 0);
        check("done_color", color, 0);
        check("done_bursts", nbursts, 1);
        check("done_underflow", underflow, 0);
        go(32'h2000);
        wait_bursts(2, 100);
        check("restart_addr", b_addr[1], 32'h2000);
        check("restart_len", b_len[1], 64);

        // RGB565, hres 641: 321 words per line, early read_next_line is held pending.
        do_reset();
        num_bytes_per_pixel = 1'b0;
        hres = 11'd641;
        read_fifo = 1'b1;
        go(32'h4000);
        repeat (3) @(negedge clock);
        read_next_line = 1'b1;
        @(negedge clock);
        read_next_line = 1'b0;
        wait_bursts(6, 2000);
        check("r565_len0", b_len[0], 64);
        check("r565_last_addr", b_addr[5], 32'h4500);
        check("r565_last_len", b_len[5], 1);
        wait_bursts(7, 500);
        check("r565_line2_addr", b_addr[6], 32'h4504);
        check("r565_line2_len", b_len[6], 64);
        read_fifo = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_pixel_fetch.md
Name: hdmi_pixel_fetch

Overview:
Upstream feeder for the HDMI output core. Fetches framebuffer lines from memory in bursts and holds them in a first-word-fall-through FIFO. Presents the FIFO head on `color`, and pops it on the core's `read_fifo`. Frame and line sequencing follow the core's `read_go`, `read_next_line` and `read_done` pulses.

Parameters:
- FIFO_DEPTH, 128, FIFO depth in 32-bit words; power of two, ≥ 2*BURST_LEN.
- BURST_LEN, 64, maximum words per memory burst; matches the core's 64-pixel chunk.
- ADDR_W, 32, memory byte-address width.

Ports:
- clock  in  1  system/pixel clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- fb_base  in  ADDR_W  framebuffer byte base address; 4-byte aligned; sampled on read_go.
- hres  in  11  active pixels per line; same value the core uses.
- num_bytes_per_pixel  in  1  1 = RGB888 (1 word/pixel), 0 = RGB565 (2 pixels/word).
- read_go  in  1  1-cycle pulse: frame start.
- read_next_line  in  1  1-cycle pulse: advance to next line.
- read_done  in  1  1-cycle pulse: frame end.
- read_fifo  in  1  pop request from the core.
- color  out  32  FIFO head word; 0 when empty.
- mem_req  out  1  burst request; held until mem_ack.
- mem_addr  out  ADDR_W  burst start byte address; stable while mem_req.
- mem_len  out  8  burst length in words, 1..BURST_LEN; stable while mem_req.
- mem_ack  in  1  request accepted (1 cycle).
- mem_rvalid  in  1  read data beat valid.
- mem_rdata  in  32  read data beat.
- underflow  out  1  sticky: pop attempted while empty; cleared by read_go.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - outputs: mem_req=0, mem_addr=0, mem_len=0, underflow=0, busy=0, color=0.
  - internal: FIFO emptied, state=IDLE.
  - Reset mid-burst abandons the burst; the memory side must be reset with it.
- words_per_line is computed combinationally:
  - RGB888: hres.
  - RGB565: ceil(hres/2) = (hres+1)>>1.
  - line_bytes = words_per_line<<2.
- free = FIFO_DEPTH − count − outstanding, where outstanding = beats requested but not yet received. Data beats can never overflow the FIFO. A beat arriving while the FIFO is full is a protocol error and is dropped; an assertion flags it.
- FSM states: IDLE, REQ, WAIT_ACK, DATA, HOLD, DRAIN.
  - IDLE: on read_go → flush FIFO, line_addr=fb_base, cur_addr=fb_base, remaining=words_per_line, clear underflow → REQ.
  - REQ:
    - If remaining=0 → HOLD.
    - Else if free ≥ min(BURST_LEN, remaining): drive mem_req=1, mem_addr=cur_addr, mem_len=min(BURST_LEN, remaining) → WAIT_ACK.
  - WAIT_ACK: hold mem_req and its fields. On mem_ack → mem_req=0; cur_addr += mem_len*4; remaining −= mem_len; beat counter = mem_len → DATA.
  - DATA: each mem_rvalid pushes mem_rdata and decrements the beat counter. The beat that takes it to 0 → REQ.
  - HOLD: on read_next_line → line_addr += line_bytes, cur_addr = new line_addr, remaining = words_per_line → REQ.
  - read_done in any non-IDLE state:
    - from REQ or HOLD → IDLE.
    - from WAIT_ACK → continue until mem_ack, then DRAIN.
    - from DATA → DRAIN.
  - DRAIN: discard beats until the beat counter reaches 0, flush FIFO → IDLE.
  - read_go outside IDLE: treated as read_done immediately followed by read_go. The frame restarts after DRAIN completes, using the fb_base captured at the pulse.
  - read_next_line while not in HOLD (line still fetching): latched as a pending flag and consumed on entry to HOLD. A second pulse while one is pending sets an assertion error.
- FIFO/pop:
  - color is combinational from the head entry, so there is zero latency to the core.
  - read_fifo with count>0 → pop that cycle.
  - read_fifo with count=0 → no pop, underflow=1 (sticky).
  - Push and pop in the same cycle: count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- The fetch is fully prefetching: it refills whenever space allows and does not depend on the core's chunk pulses.

Decomposition:
- Shared package hdmi_pkg holds:
  - FSM state enum.
  - BPP_RGB888=1, BPP_RGB565=0.
  - Helper function words_per_line(hres, bpp).
- One sub-module: hdmi_fwft_fifo (parameterised depth/width; push, pop, count, full, empty; synchronous reset_n flush plus a flush input).

Test Plan:
- RGB888, hres=800, fb_base=0x1000, read_go: first request addr=0x1000 len=64; 13 bursts per line, last len=32 (800=12*64+32); after read_next_line, next request addr=0x1000+3200=0x1C80.
- RGB565, hres=641: words_per_line=321; last burst of each line len=1; line stride 1284 bytes.
- Pop timing: after one burst of 0..63, hold read_fifo high for 64 cycles → color sequence 0,1,...,63; FIFO empty; underflow stays 0. One extra pop → underflow=1, color=0.
- Backpressure: FIFO_DEPTH=128 with no pops → exactly 2 bursts issued, then mem_req stays 0 until ≥64 words are popped.
- read_done during DATA with 20 beats outstanding: all 20 beats accepted and discarded, FIFO count=0, state=IDLE, busy=0; next read_go restarts at fb_base.
- reset_n=0 for one cycle while mem_req=1 → next cycle mem_req=0, color=0, busy=0, underflow=0.
